// File: rtl/adc_trigger_capture.sv
// Captures DEPTH delayed ADC samples on a rising threshold crossing and streams them as bytes.
// Latency: tx_valid one cycle after SEND entry, then 1 byte/cycle; ADC_CAPTURE_TIMESTAMP_EN adds a 4-byte trigger timestamp.
// Backpressure: tx_data/tx_valid held until tx_ready; capture itself never stalls.
module adc_trigger_capture #(
    parameter int         DATA_W = 14,
    parameter int         DEPTH  = 64,
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] adc_in,
    input  logic [DATA_W-1:0] delayed_in,
    input  logic [DATA_W-1:0] threshold,
    input  logic              arm,
    output logic              busy,
    output logic              done,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);
    localparam int AW = $clog2(DEPTH);
`ifdef ADC_CAPTURE_TIMESTAMP_EN
    localparam int PRE_N = 5;
`else
    localparam int PRE_N = 1;
`endif
    localparam int NBYTES = 2 * DEPTH + PRE_N;
    localparam int BW     = $clog2(NBYTES + 1);
    localparam logic [AW-1:0] W_LAST = AW'(DEPTH - 1);
    localparam logic [BW-1:0] B_LAST = BW'(NBYTES);
    localparam logic [BW-1:0] B_PRE  = BW'(PRE_N);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, SEND} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] prev_sample;
    logic [DATA_W-1:0] rd_dat;
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [BW-1:0]     bidx;
    logic              trig;
    logic              mem_we;
    logic              load;
    logic [7:0]        nxt_byte;

    assign trig   = (prev_sample <= threshold) && (adc_in > threshold);
    assign mem_we = (state == ARMED && trig) || (state == CAPTURE);
    // bidx counts bytes already placed in tx_data; a new one loads whenever the slot is free
    assign load   = (state == SEND) && (bidx != B_LAST) && (!tx_valid || tx_ready);

    // Read is registered and only advances on a load, so rd_dat always holds the sample being sent
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wptr] <= delayed_in;
        if (load)
            rd_dat <= mem[rptr];
    end

`ifdef ADC_CAPTURE_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt <= '0;
            ts_lat <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (state == ARMED && trig)
                ts_lat <= ts_cnt;
        end
    end
`endif

    always_comb begin
        nxt_byte = HEADER;
        if (bidx >= B_PRE)
            // PRE_N is odd, so an odd byte index is the high byte of a sample
            nxt_byte = bidx[0] ? {2'b00, rd_dat[13:8]} : rd_dat[7:0];
`ifdef ADC_CAPTURE_TIMESTAMP_EN
        else begin
            case (bidx[2:0])
                3'd1:    nxt_byte = ts_lat[31:24];
                3'd2:    nxt_byte = ts_lat[23:16];
                3'd3:    nxt_byte = ts_lat[15:8];
                3'd4:    nxt_byte = ts_lat[7:0];
                default: nxt_byte = HEADER;
            endcase
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            wptr        <= '0;
            rptr        <= '0;
            bidx        <= '0;
            prev_sample <= '0;
        end else begin
            prev_sample <= adc_in;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        state <= ARMED;
                        busy  <= 1'b1;
                        wptr  <= '0;
                    end
                end
                ARMED: begin
                    if (trig) begin
                        state <= CAPTURE;
                        wptr  <= AW'(1);
                    end
                end
                CAPTURE: begin
                    wptr <= wptr + 1'b1;
                    if (wptr == W_LAST) begin
                        state <= SEND;
                        rptr  <= '0;
                        bidx  <= '0;
                    end
                end
                SEND: begin
                    if (load) begin
                        tx_valid <= 1'b1;
                        tx_data  <= nxt_byte;
                        bidx     <= bidx + 1'b1;
                        if (bidx >= B_PRE && bidx[0])
                            rptr <= rptr + 1'b1;
                    end else if (tx_valid && tx_ready) begin
                        // nothing left to load, so this acceptance was the final byte
                        tx_valid <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/adc_trigger_capture.md
Name: adc_trigger_capture

Overview:
- Sits directly downstream of the 6-stage ADC sample delay line.
- Watches the live 14-bit ADC sample for a rising threshold crossing.
- On a crossing, records DEPTH samples from the 6-cycle-delayed tap into an internal buffer, which gives 6 pre-trigger samples per record.
- Then streams the record as bytes to the UART transmitter over a valid/ready handshake.

Parameters:
- DATA_W, 14, ADC sample width; fixed at 14 by the byte format below.
- DEPTH, 64, samples per record; power of two, 8..1024.
- HEADER, 8'hA5, first byte of every record.

Ports:
- clk  in  1  sample clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- adc_in  in  14  live ADC sample, used for the trigger compare only.
- delayed_in  in  14  6-cycle-delayed sample; this is the recorded data.
- threshold  in  14  unsigned trigger level; sampled each cycle.
- arm  in  1  level or pulse; arms the capture when sampled in IDLE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the last byte of a record is accepted.
- tx_data  out  8  byte to the UART.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART accepts the byte.

Behaviour:
- Reset values (async, on rst_n low): state IDLE; busy, done, tx_valid = 0; tx_data = 0; write pointer = 0; read pointer = 0; prev_sample = 0. Buffer contents are don't-care.
- prev_sample <= adc_in on every clock, in all states.
- Trigger condition: prev_sample <= threshold AND adc_in > threshold, both unsigned. Equality on the current sample does not trigger.
- IDLE -> ARMED when arm = 1.
- ARMED -> CAPTURE on the trigger condition. In the trigger cycle, buf[0] <= delayed_in and wptr <= 1.
- CAPTURE: buf[wptr] <= delayed_in every cycle. After buf[DEPTH-1] is written, go to SEND. Capture time is exactly DEPTH cycles including the trigger cycle.
- SEND order: byte sequence is HEADER, then for each i = 0..DEPTH-1: {2'b00, s[13:8]} followed by s[7:0]. Total is 2*DEPTH+1 bytes.
- SEND timing: tx_valid rises no later than 2 cycles after SEND entry. Buffer read latency is hidden by prefetch.
- Handshake: a transfer occurs on a clock where tx_valid and tx_ready are both 1. tx_valid is never deasserted without a transfer. tx_data is stable while tx_valid = 1 and tx_ready = 0. Back-to-back transfers are sustained at 1 byte/cycle when tx_ready is held high.
- After the last byte transfers: done = 1 for one cycle, tx_valid = 0, go to IDLE.
- arm asserted in ARMED, CAPTURE or SEND is ignored. Retrigger conditions during CAPTURE or SEND are ignored.
- If adc_in is already above threshold when armed, a fresh crossing is required: it must fall to <= threshold, then rise above it.
- Reset asserted mid-capture or mid-send: immediate abort, all outputs at reset values, partial record discarded. The next arm works normally.
- Threshold changes take effect on the next compare; no shadowing.

Optional Feature:
- Macro: ADC_CAPTURE_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running counter increments every clk and resets to 0. It wraps at 2^32 to 0.
  - Its value in the trigger cycle is latched.
  - Four timestamp bytes, MSB first, are inserted after HEADER and before the first sample byte. Total is 2*DEPTH+5 bytes.
- Undefined: no counter and no timestamp bytes. Byte stream is exactly as in Behaviour.

Test Plan:
- Reset check: hold rst_n = 0 with arm = 1 and a ramp on adc_in -> busy = 0, tx_valid = 0, tx_data = 0, no state change. Release -> IDLE.
- Basic record:
  - Setup: DEPTH = 8, threshold = 1000, adc_in = delayed_in source ramp 990, 991, ..., with delayed_in being the ramp delayed 6 cycles; tx_ready = 1; pulse arm.
  - Expected trigger: at adc_in = 1001.
  - Expected stream: 17 bytes, A5, then samples 995..1002 as high/low pairs, e.g. 03 E3 for 995; done pulses once.
- Boundary compare:
  - adc_in 999 -> 1000 -> 1000 with threshold 1000 -> no trigger.
  - Then 1000 -> 1001 -> trigger.
  - Armed while adc_in = 2000: no trigger until it drops to <= 1000 and recrosses.
- Backpressure: tx_ready toggles randomly, then is held 0 for 20 cycles mid-record -> tx_valid stays 1, tx_data unchanged, no byte lost or duplicated, byte count = 2*DEPTH+1.
- Ignored and abort:
  - arm pulses and threshold crossings during SEND -> no effect on the stream.
  - rst_n low mid-SEND -> tx_valid = 0 asynchronously; after release, a new arm and crossing yield a complete, correct record.
- With ADC_CAPTURE_TIMESTAMP_EN: trigger at the 300th clock after reset release -> bytes 2..5 = 00 00 01 2B (counter = 299), then the sample bytes.
